scan_display_ctrl: RTL
======================

Name: scan_display_ctrl

Overview:
- Parametrised successor to the 3-digit address display: drives a DIGITS-wide multiplexed common-anode seven-segment display from a DATA_WIDTH binary value.
- Adds a sequential shift-add-3 (double-dabble) converter, a hex mode, leading-zero blanking, per-digit decimal points, overflow indication and tear-free frame updates.
- Sits between the ROM reader address/data counters and the board display pins.

Parameters:
- DATA_WIDTH, 9, width of the input value.
- DIGITS, 4, number of display digits (2..8).
- SCAN_DIV, 8, clk cycles each digit is held enabled (>=2).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- value  input  DATA_WIDTH  binary value to show.
- hex_mode  input  1  1 = hex nibbles, 0 = decimal.
- blank_zeros  input  1  1 = blank leading zeros.
- dp_mask  input  DIGITS  bit i lights the decimal point of digit i.
- sseg_indicator  output  8  segments, active-low; bit7 = dp, bits6:0 = g..a.
- digits  output  DIGITS  one-hot digit enable, active-high; bit0 = least significant digit.
- overflow  output  1  the displayed frame's value did not fit in DIGITS digits.

Behaviour:
- Reset (async assert, sync release): digits = 1, sseg_indicator = 8'hFF, overflow = 0, prescaler = 0, digit index = 0, display register = all blank, converter idle.
- Prescaler counts 0..SCAN_DIV-1. At the terminal count:
  - the digit index increments, wrapping DIGITS-1 -> 0;
  - digits rotates left with wrap, e.g. 1000 -> 0001 for DIGITS = 4;
  - sseg_indicator registers the code for the new index.
  - Both outputs change in the same cycle; digits is never zero and never multi-hot.
- Frame boundary: the index wraps to 0. At each frame boundary:
  - the pending result, if any, is committed to the display register;
  - value, hex_mode and blank_zeros are sampled;
  - a new conversion starts if the converter is idle.
- Input changes between boundaries are ignored. A value sampled at frame F is displayed from frame F+1. If the converter is still busy, the start is skipped and the old display is retained.
- Decimal conversion: DATA_WIDTH iterations, one per clk (add 3 to each BCD nibble >= 5, then shift left). done is asserted on cycle DATA_WIDTH+1 after start.
- Overflow (decimal): the required decimal digit count exceeds DIGITS, i.e. value >= 10^DIGITS. Detected via an extra carry nibble.
  - Every digit shows 8'hBF ("-", dp still applied).
  - overflow = 1 for that frame.
- Overflow (hex): value does not fit in 4*DIGITS bits, with the same response.
- Hex mode: nibble i = value[4i+3:4i], zero-extended. Result is ready 1 cycle after start.
- Leading-zero blanking: when blank_zeros = 1, every zero nibble above the most significant non-zero nibble shows 8'hFF. Digit 0 is never blanked.
- Segment codes:
  - digits 0..9: C0 F9 A4 B0 99 92 82 F8 80 90;
  - A..F: 88 83 C6 A1 86 8E;
  - blank: FF.
- dp_mask[i] = 1 clears bit7 for digit i, including on blanked digits. dp_mask is sampled live, not per frame.
- Reset mid-conversion aborts the conversion and discards the pending result. The display is blank until the first commit after reset; overflow stays 0 until that commit.
- DIGITS*SCAN_DIV < DATA_WIDTH+2 is legal. The result then lands every second frame.

Decomposition:
- Shared package scan_display_pkg holds:
  - the segment code constants (SSEG_0..SSEG_F, SSEG_BLANK = 8'hFF, SSEG_DASH = 8'hBF);
  - a clog2 function for index width;
  - the max-DIGITS constant.
- Sub-module bin2bcd_seq: start/busy/done handshake, DATA_WIDTH input, 4*(DIGITS+1) BCD output including the overflow nibble. It is reused by the data display.
- The top level holds the prescaler, scan FSM, pending/display registers, blanking and encoding.

Test Plan:
- DIGITS=4, value=255, dec, blank_zeros=1 -> per frame, digit0..3 sseg = 92, 92, A4, FF; overflow=0; each digit enabled exactly 8 clk.
- value=0, blank_zeros=1, dp_mask=4'b0100 -> digit0 = C0, digit1 = FF, digit2 = 7F, digit3 = FF.
- hex_mode=1, value=9'h1AB, blank_zeros=0 -> digit0..3 = 83, 88, F9, C0.
- DIGITS=2, value=100 -> both digits BF, overflow=1. Then value=99 -> 90, 90 from frame F+1, overflow=0.
- Change value from 5 to 7 mid-frame, then assert reset mid-conversion -> no torn frame; after reset digits=1, sseg=FF; shows F8 only after the next full frame.
- DATA_WIDTH=16, DIGITS=4, SCAN_DIV=2 (frame=8 < 18) -> value 1234 commits on alternate frames: digit0..3 = 99, B0, A4, F9; digits rotation uninterrupted.

Source files
------------

// File: rtl/scan_display_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Segment codes are active-low: bit7 = dp, bits6:0 = g..a.
package scan_display_pkg;

  localparam int unsigned MAX_DIGITS = 8;

  localparam logic [7:0] SSEG_0     = 8'hC0;
  localparam logic [7:0] SSEG_1     = 8'hF9;
  localparam logic [7:0] SSEG_2     = 8'hA4;
  localparam logic [7:0] SSEG_3     = 8'hB0;
  localparam logic [7:0] SSEG_4     = 8'h99;
  localparam logic [7:0] SSEG_5     = 8'h92;
  localparam logic [7:0] SSEG_6     = 8'h82;
  localparam logic [7:0] SSEG_7     = 8'hF8;
  localparam logic [7:0] SSEG_8     = 8'h80;
  localparam logic [7:0] SSEG_9     = 8'h90;
  localparam logic [7:0] SSEG_A     = 8'h88;
  localparam logic [7:0] SSEG_B     = 8'h83;
  localparam logic [7:0] SSEG_C     = 8'hC6;
  localparam logic [7:0] SSEG_D     = 8'hA1;
  localparam logic [7:0] SSEG_E     = 8'h86;
  localparam logic [7:0] SSEG_F     = 8'h8E;
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_DASH  = 8'hBF;

  // Index/counter width; never below 1 so a 2-entry range still gets a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [7:0] sseg_code(input logic [3:0] nib);
    logic [7:0] c;
    c = SSEG_BLANK;
    case (nib)
      4'h0: c = SSEG_0;
      4'h1: c = SSEG_1;
      4'h2: c = SSEG_2;
      4'h3: c = SSEG_3;
      4'h4: c = SSEG_4;
      4'h5: c = SSEG_5;
      4'h6: c = SSEG_6;
      4'h7: c = SSEG_7;
      4'h8: c = SSEG_8;
      4'h9: c = SSEG_9;
      4'hA: c = SSEG_A;
      4'hB: c = SSEG_B;
      4'hC: c = SSEG_C;
      4'hD: c = SSEG_D;
      4'hE: c = SSEG_E;
      4'hF: c = SSEG_F;
      default: c = SSEG_BLANK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/scan_display_ctrl_if.sv
// Value/mode inputs and display pin outputs of the scanned display controller.
interface scan_display_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DIGITS     = 4
);
  logic [DATA_WIDTH-1:0] value;
  logic                  hex_mode;
  logic                  blank_zeros;
  logic [DIGITS-1:0]     dp_mask;
  logic [7:0]            sseg_indicator;
  logic [DIGITS-1:0]     digits;
  logic                  overflow;

  modport master (
    output value, hex_mode, blank_zeros, dp_mask,
    input  sseg_indicator, digits, overflow
  );

  modport slave (
    input  value, hex_mode, blank_zeros, dp_mask,
    output sseg_indicator, digits, overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 binary to BCD converter, one bit per clock.
// The top nibble is a carry digit; it reads 4'hF if even wider digits were lost.
module bin2bcd_seq
  import scan_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DIGITS     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic [DATA_WIDTH-1:0]     bin_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [4*(DIGITS+1)-1:0]   bcd_o
);
  localparam int unsigned BW = 4 * (DIGITS + 1);
  localparam int unsigned IW = clog2(DATA_WIDTH);

  typedef enum logic [1:0] {CONV_IDLE, CONV_RUN, CONV_DONE} conv_state_e;

  conv_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]         bcd_q, bcd_d, adj;
  logic                  sticky_q, sticky_d;
  logic [IW-1:0]         iter_q, iter_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= CONV_IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      sticky_q <= 1'b0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      sticky_q <= sticky_d;
      iter_q   <= iter_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    sticky_d = sticky_q;
    iter_d   = iter_q;
    adj      = bcd_q;
    for (int unsigned i = 0; i < DIGITS + 1; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    case (state_q)
      CONV_IDLE: begin
        if (start_i) begin
          bin_d    = bin_i;
          bcd_d    = '0;
          sticky_d = 1'b0;
          iter_d   = '0;
          state_d  = CONV_RUN;
        end
      end
      CONV_RUN: begin
        // A bit leaving the carry nibble means a digit beyond DIGITS+1 is non-zero.
        bcd_d    = {adj[BW-2:0], bin_q[DATA_WIDTH-1]};
        bin_d    = bin_q << 1;
        sticky_d = sticky_q | adj[BW-1];
        iter_d   = iter_q + IW'(1);
        if (iter_q == IW'(DATA_WIDTH - 1)) state_d = CONV_DONE;
      end
      CONV_DONE: state_d = CONV_IDLE;
      default:   state_d = CONV_IDLE;
    endcase
  end

  assign busy_o = (state_q != CONV_IDLE);
  assign done_o = (state_q == CONV_DONE);
  assign bcd_o  = sticky_q ? {4'hF, bcd_q[BW-5:0]} : bcd_q;

endmodule

// File: rtl/scan_display_ctrl.sv
// Multiplexed common-anode display driver: prescaled digit scan, frame-synchronous
// sampling and commit of a decimal/hex conversion, zero blanking and dp overlay.
module scan_display_ctrl
  import scan_display_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned SCAN_DIV   = 8
) (
  input  logic                clk,
  input  logic                reset,
  scan_display_ctrl_if.slave  io
);
  localparam int unsigned NW = 4 * DIGITS;
  localparam int unsigned CW = clog2(SCAN_DIV);
  localparam int unsigned IW = clog2(DIGITS);
  localparam int unsigned XW = (DATA_WIDTH > NW) ? DATA_WIDTH : NW;

  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   dig_q, dig_d;
  logic [7:0]          sseg_q, sseg_d;
  logic [NW-1:0]       disp_nib_q, disp_nib_d, pend_nib_q, pend_nib_d, shw_nib;
  logic [DIGITS-1:0]   disp_blank_q, disp_blank_d, pend_blank_q, pend_blank_d, shw_blank;
  logic                disp_ovf_q, disp_ovf_d, pend_ovf_q, pend_ovf_d, shw_ovf;
  logic                pend_valid_q, pend_valid_d;
  logic                blank_en_q, blank_en_d;
  logic                tick, boundary, commit, start;
  logic                conv_busy, conv_done;
  logic [4*(DIGITS+1)-1:0] conv_bcd;
  logic [XW-1:0]       val_x;
  logic [7:0]          code;

  function automatic logic [DIGITS-1:0] lz_mask(input logic [NW-1:0] nib, input logic en);
    logic [DIGITS-1:0] m;
    logic              zero_run;
    m        = '0;
    zero_run = 1'b1;
    for (int unsigned k = 1; k < DIGITS; k++) begin
      zero_run        = zero_run && (nib[4*(DIGITS-k) +: 4] == 4'd0);
      m[DIGITS-k]     = en && zero_run;
    end
    return m;
  endfunction

  bin2bcd_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIGITS     (DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (reset),
    .start_i (start && !io.hex_mode),
    .bin_i   (io.value),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      dig_q        <= DIGITS'(1);
      sseg_q       <= SSEG_BLANK;
      disp_nib_q   <= '0;
      disp_blank_q <= '1;
      disp_ovf_q   <= 1'b0;
      pend_nib_q   <= '0;
      pend_blank_q <= '1;
      pend_ovf_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      blank_en_q   <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dig_q        <= dig_d;
      sseg_q       <= sseg_d;
      disp_nib_q   <= disp_nib_d;
      disp_blank_q <= disp_blank_d;
      disp_ovf_q   <= disp_ovf_d;
      pend_nib_q   <= pend_nib_d;
      pend_blank_q <= pend_blank_d;
      pend_ovf_q   <= pend_ovf_d;
      pend_valid_q <= pend_valid_d;
      blank_en_q   <= blank_en_d;
    end
  end

  always_comb begin
    tick     = (cnt_q == CW'(SCAN_DIV - 1));
    boundary = tick && (idx_q == IW'(DIGITS - 1));
    commit   = boundary && pend_valid_q;
    start    = boundary && !conv_busy;

    cnt_d = tick ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    dig_d = dig_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + IW'(1);
      dig_d = {dig_q[DIGITS-2:0], dig_q[DIGITS-1]};
    end

    // Digit 0 of the new frame must already see the freshly committed result.
    shw_nib      = commit ? pend_nib_q   : disp_nib_q;
    shw_blank    = commit ? pend_blank_q : disp_blank_q;
    shw_ovf      = commit ? pend_ovf_q   : disp_ovf_q;
    disp_nib_d   = shw_nib;
    disp_blank_d = shw_blank;
    disp_ovf_d   = shw_ovf;

    val_x        = XW'(io.value);
    pend_nib_d   = pend_nib_q;
    pend_blank_d = pend_blank_q;
    pend_ovf_d   = pend_ovf_q;
    pend_valid_d = pend_valid_q && !commit;
    blank_en_d   = start ? io.blank_zeros : blank_en_q;
    if (start && io.hex_mode) begin
      pend_nib_d   = val_x[NW-1:0];
      pend_ovf_d   = ((val_x >> NW) != '0);
      pend_blank_d = lz_mask(val_x[NW-1:0], io.blank_zeros);
      pend_valid_d = 1'b1;
    end else if (conv_done) begin
      pend_nib_d   = conv_bcd[NW-1:0];
      pend_ovf_d   = (conv_bcd[NW +: 4] != 4'd0);
      pend_blank_d = lz_mask(conv_bcd[NW-1:0], blank_en_q);
      pend_valid_d = 1'b1;
    end

    code = sseg_code(shw_nib[4*idx_d +: 4]);
    if (shw_blank[idx_d]) code = SSEG_BLANK;
    if (shw_ovf)          code = SSEG_DASH;
    code[7] = code[7] & ~io.dp_mask[idx_d];
    sseg_d  = tick ? code : sseg_q;
  end

  assign io.sseg_indicator = sseg_q;
  assign io.digits         = dig_q;
  assign io.overflow       = disp_ovf_q;

endmodule
